// File: rtl/cache_pmem_arbiter.sv
// Shares the single physical-memory line port between the I-cache and the D-cache.
// Simultaneous requests are arbitrated round-robin. The winner's request is latched
// into registered pmem outputs, and the memory response is routed back to that
// cache only.
module cache_pmem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_WIDTH  = 256,
   parameter int OFFSET_BITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_pmem_read,
   input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
   output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
   output logic                  icache_pmem_resp,
   input  logic                  dcache_pmem_read,
   input  logic                  dcache_pmem_write,
   input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
   input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
   output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
   output logic                  dcache_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      DONE   = 2'd3
   } state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   state_e                state_q, state_d;
   grant_e                last_grant_q, last_grant_d;
   logic                  pmem_read_q, pmem_read_d;
   logic                  pmem_write_q, pmem_write_d;
   logic [ADDR_WIDTH-1:0] pmem_address_q, pmem_address_d;
   logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;

   logic i_req;
   logic d_req;
   logic pick_d;

   // Line offsets never reach memory; only the line-aligned upper bits are used.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{icache_pmem_address[OFFSET_BITS-1:0],
                                 dcache_pmem_address[OFFSET_BITS-1:0]};

   assign i_req  = icache_pmem_read;
   assign d_req  = dcache_pmem_read | dcache_pmem_write;
   // On a tie the cache that did not win last time gets the port.
   assign pick_d = d_req & (~i_req | (last_grant_q == GRANT_I));

   // State register: FSM state, round-robin pointer and the registered pmem request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         last_grant_q   <= GRANT_I;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
      end
   end

   // Next-state logic: grant from IDLE, wait for memory while busy, then one DONE
   // cycle so a requester's still-held request cannot immediately re-grant.
   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d        = D_BUSY;
               last_grant_d   = GRANT_D;
               pmem_address_d = {dcache_pmem_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
               pmem_write_d   = dcache_pmem_write;
               pmem_read_d    = dcache_pmem_read & ~dcache_pmem_write;
               if (dcache_pmem_write) begin
                  pmem_wdata_d = dcache_pmem_wdata;
               end
            end else if (i_req) begin
               state_d        = I_BUSY;
               last_grant_d   = GRANT_I;
               pmem_address_d = {icache_pmem_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
               pmem_read_d    = 1'b1;
               pmem_write_d   = 1'b0;
            end
         end
         I_BUSY, D_BUSY: begin
            if (pmem_resp) begin
               state_d      = DONE;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: the memory response goes only to the cache that owns the port.
   always_comb begin
      icache_pmem_resp  = 1'b0;
      dcache_pmem_resp  = 1'b0;
      icache_pmem_rdata = pmem_rdata;
      dcache_pmem_rdata = pmem_rdata;
      if (rst) begin
         icache_pmem_rdata = '0;
         dcache_pmem_rdata = '0;
      end else if (pmem_resp) begin
         icache_pmem_resp = (state_q == I_BUSY);
         dcache_pmem_resp = (state_q == D_BUSY);
      end
   end

   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: doc/cache_pmem_arbiter.md
Name: cache_pmem_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache and the D-cache.
- Arbitrates round-robin on simultaneous requests and latches the winner's address and write data into registered pmem outputs.
- Routes pmem_resp and pmem_rdata back to the granted cache only.
- Sits between both caches and the cacheline adaptor/pmem. Its address-select state matches the arbiteraddressmux select used in the datapath.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cache line width in bits
OFFSET_BITS, 5, line-offset bits forced to zero on pmem_address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
icache_pmem_read  in  1  I-cache line read request, held until icache_pmem_resp
icache_pmem_address  in  ADDR_WIDTH  I-cache line address
icache_pmem_rdata  out  LINE_WIDTH  line returned to I-cache
icache_pmem_resp  out  1  one-cycle completion to I-cache
dcache_pmem_read  in  1  D-cache line read request
dcache_pmem_write  in  1  D-cache writeback request
dcache_pmem_address  in  ADDR_WIDTH  D-cache line address
dcache_pmem_wdata  in  LINE_WIDTH  writeback line
dcache_pmem_rdata  out  LINE_WIDTH  line returned to D-cache
dcache_pmem_resp  out  1  one-cycle completion to D-cache
pmem_read  out  1  registered read to memory
pmem_write  out  1  registered write to memory
pmem_address  out  ADDR_WIDTH  registered, low OFFSET_BITS = 0
pmem_wdata  out  LINE_WIDTH  registered write line
pmem_rdata  in  LINE_WIDTH  memory read line
pmem_resp  in  1  memory completion

Behaviour:
- Reset:
  - State: IDLE; last_grant: ICACHE, so the D-cache wins the first tie.
  - Registered outputs: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Cache responses: icache_pmem_resp=0, dcache_pmem_resp=0, rdata outputs=0.
  - A reset mid-transaction abandons it. Outputs are 0 from the next edge, and a pmem_resp arriving later is ignored in IDLE.
- FSM states: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE:
  - Only I requests -> I_BUSY. Only D requests (read or write) -> D_BUSY.
  - Both request -> grant the opposite of last_grant. last_grant updates on every grant.
  - On grant, at the same edge, register pmem_address = {addr[ADDR_WIDTH-1:OFFSET_BITS], 0}.
  - For a D-cache write, also register pmem_wdata = dcache_pmem_wdata.
  - pmem_read / pmem_write are registered per request type. If dcache read and write are both high, write wins and read is dropped.
- I_BUSY / D_BUSY:
  - Registered pmem outputs hold constant; requester inputs are not re-sampled.
  - While pmem_resp=0: stay, and both cache resp outputs are 0.
  - When pmem_resp=1: granted cache resp=1 and its rdata=pmem_rdata combinationally in the same cycle; the non-granted cache sees resp=0. Next state DONE, with pmem_read/write cleared at that edge.
- DONE:
  - One cycle with all requests ignored, so the requester's stale held request cannot re-grant; then IDLE.
  - pmem_resp in DONE or IDLE is ignored.
- Latency:
  - Request visible in IDLE at cycle t -> pmem_read/write high at t+1.
  - pmem_resp at cycle k -> cache resp at k. DONE at k+1, IDLE at k+2, earliest next pmem_read at k+3.
- A loser's request stays pending, unchanged, through the whole winner transaction and is granted from the next IDLE.
- Back-to-back requests from one cache with no contention each incur the fixed DONE+IDLE bubble.
- rdata outputs when not responding: pass pmem_rdata through (don't-care for caches). The bench checks rdata only when resp=1.

Test Plan:
- Reset, then I-only read at 0x0000_1234 -> cycle+1 pmem_read=1, pmem_address=0x0000_1220; pmem_resp after 5 cycles with rdata=0xA5..A5 -> icache_pmem_resp=1 and rdata match the same cycle; dcache_pmem_resp stays 0.
- D-only write at 0x8000_0040, wdata=0x1111..1111 -> pmem_write=1, pmem_read=0, pmem_wdata latched; change dcache_pmem_wdata during busy -> pmem_wdata unchanged.
- Simultaneous I read 0x100 and D read 0x200 right after reset -> D granted first (pmem_address=0x200); I granted at resp+3 cycles with 0x100; the next tie grants I-then-D alternation.
- Requester keeps request high during DONE -> no second grant. It drops at k+1 and no pmem_read occurs at k+2 or later.
- Assert rst while in D_BUSY -> next cycle pmem_read=pmem_write=0 and state IDLE; a late pmem_resp produces no cache resp.
- dcache read and write both high at 0x40 -> pmem_write=1, pmem_read=0; pmem_resp at cycle k produces dcache_pmem_resp=1 at k.
